// File: rtl/uart_mouse_cmd_rx.sv
// 8N1 UART receiver feeding a mouse-report frame parser.
// Valid frames land in a report register with valid/ready handshake and delta coalescing.
module uart_mouse_cmd_rx #(
  parameter int CLK_HZ         = 60000000,
  parameter int BAUD           = 115200,
  parameter int DELTA_W        = 8,
  parameter int TIMEOUT_CYCLES = 600000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [7:0]         report_buttons,
  output logic [DELTA_W-1:0] report_dx,
  output logic [DELTA_W-1:0] report_dy,
  output logic [DELTA_W-1:0] report_wheel,
  output logic               err_framing,
  output logic               err_checksum,
  output logic               err_timeout,
  output logic               busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int NB   = DELTA_W / 8;
  localparam int PL   = 1 + 3 * NB;
  localparam int IW   = $clog2(PL + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  typedef enum logic [1:0] {P_IDLE, P_PAYLOAD, P_CHECK} pstate_t;

  logic sync1_q, sync2_q, prev_q;
  rstate_t rs_q, rs_d;
  pstate_t ps_q, ps_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [8*PL-1:0]   pay_q, pay_d;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              rv_q, rv_d;
  logic [7:0]        rb_q, rb_d;
  logic [DELTA_W-1:0] rdx_q, rdx_d, rdy_q, rdy_d, rwh_q, rwh_d;
  logic ef_q, ec_q, et_q;

  logic start_det, samp, byte_stb, frm_err;
  logic busy_c, tmo_hit, commit, cks_err, xfer;

  function automatic logic [DELTA_W-1:0] sat_add(
    input logic [DELTA_W-1:0] a,
    input logic [DELTA_W-1:0] b
  );
    logic signed [DELTA_W:0] s;
    s = $signed({a[DELTA_W-1], a}) + $signed({b[DELTA_W-1], b});
    if (s[DELTA_W] != s[DELTA_W-1])
      return s[DELTA_W] ? {1'b1, {(DELTA_W-1){1'b0}}}
                        : {1'b0, {(DELTA_W-1){1'b1}}};
    return s[DELTA_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      rs_q    <= R_IDLE;
      ps_q    <= P_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      pay_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      rv_q    <= 1'b0;
      rb_q    <= '0;
      rdx_q   <= '0;
      rdy_q   <= '0;
      rwh_q   <= '0;
      ef_q    <= 1'b0;
      ec_q    <= 1'b0;
      et_q    <= 1'b0;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rs_q    <= rs_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      rv_q    <= rv_d;
      rb_q    <= rb_d;
      rdx_q   <= rdx_d;
      rdy_q   <= rdy_d;
      rwh_q   <= rwh_d;
      ef_q    <= frm_err;
      ec_q    <= cks_err;
      et_q    <= tmo_hit;
    end
  end

  // Event decode: a stop sample yields either a byte or a framing error.
  always_comb begin
    start_det = (rs_q == R_IDLE) && prev_q && !sync2_q;
    samp      = (rs_q == R_STOP) && (cnt_q == CW'(DIV - 1));
    byte_stb  = samp && sync2_q;
    frm_err   = samp && !sync2_q;
    busy_c    = (ps_q != P_IDLE);
    tmo_hit   = busy_c && (tmo_q > TLIM) && !samp;
    commit    = (ps_q == P_CHECK) && byte_stb && (sh_q == sum_q);
    cks_err   = (ps_q == P_CHECK) && byte_stb && (sh_q != sum_q);
    xfer      = rv_q && report_ready;
  end

  always_comb begin
    rs_d  = rs_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    unique case (rs_q)
      R_IDLE: begin
        cnt_d = '0;
        if (start_det) rs_d = R_START;
      end
      R_START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        rs_d  = sync2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d = '0;
        sh_d  = {sync2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) rs_d = R_STOP;
      end
      R_STOP: if (samp) begin
        cnt_d = '0;
        rs_d  = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase

    ps_d  = ps_q;
    idx_d = idx_q;
    pay_d = pay_q;
    sum_d = sum_q;
    tmo_d = (tmo_q != TMAX) ? tmo_q + 1'b1 : tmo_q;
    if (!busy_c || samp) tmo_d = '0;
    if (frm_err || tmo_hit) begin
      ps_d = P_IDLE;
    end else if (byte_stb) begin
      unique case (ps_q)
        P_IDLE: if (sh_q == 8'hA5) begin
          ps_d  = P_PAYLOAD;
          idx_d = '0;
          sum_d = '0;
        end
        P_PAYLOAD: begin
          pay_d[idx_q*8 +: 8] = sh_q;
          sum_d = sum_q + sh_q;
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(PL - 1)) ps_d = P_CHECK;
        end
        default: ps_d = P_IDLE;
      endcase
    end

    rv_d  = rv_q;
    rb_d  = rb_q;
    rdx_d = rdx_q;
    rdy_d = rdy_q;
    rwh_d = rwh_q;
    // A commit on top of an untaken report merges deltas instead of losing them.
    if (commit) begin
      rv_d = 1'b1;
      rb_d = pay_q[7:0];
      if (!rv_q || xfer) begin
        rdx_d = pay_q[8 +: DELTA_W];
        rdy_d = pay_q[8+DELTA_W +: DELTA_W];
        rwh_d = pay_q[8+2*DELTA_W +: DELTA_W];
      end else begin
        rdx_d = sat_add(rdx_q, pay_q[8 +: DELTA_W]);
        rdy_d = sat_add(rdy_q, pay_q[8+DELTA_W +: DELTA_W]);
        rwh_d = sat_add(rwh_q, pay_q[8+2*DELTA_W +: DELTA_W]);
      end
    end else if (xfer) begin
      rv_d = 1'b0;
    end
  end

  assign report_valid   = rv_q;
  assign report_buttons = rb_q;
  assign report_dx      = rdx_q;
  assign report_dy      = rdy_q;
  assign report_wheel   = rwh_q;
  assign err_framing    = ef_q;
  assign err_checksum   = ec_q;
  assign err_timeout    = et_q;
  assign busy           = busy_c;

endmodule

// File: tb/tb_uart_mouse_cmd_rx.sv
// Bench for uart_mouse_cmd_rx: directed and random frames vs a
// frame-level reference model with delta coalescing.
module tb_uart_mouse_cmd_rx;

  localparam int DIV = 10;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic report_ready = 1'b0;
  logic report_valid, busy;
  logic [7:0] report_buttons;
  logic [DW-1:0] report_dx, report_dy, report_wheel;
  logic err_framing, err_checksum, err_timeout;

  uart_mouse_cmd_rx #(
    .CLK_HZ(1000000), .BAUD(100000), .DELTA_W(DW), .TIMEOUT_CYCLES(300)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .report_valid(report_valid), .report_ready(report_ready),
    .report_buttons(report_buttons), .report_dx(report_dx),
    .report_dy(report_dy), .report_wheel(report_wheel),
    .err_framing(err_framing), .err_checksum(err_checksum),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int b; int dx; int dy; int wh;} rep_t;
  rep_t got_q[$];
  rep_t exp_q[$];
  rep_t m_r;
  int m_v = 0;
  int checks = 0, failures = 0;
  int n_ef = 0, n_ec = 0, n_et = 0, wide = 0;
  logic pef = 0, pec = 0, pet = 0;

  always @(negedge clk) begin
    if (rst) begin
      pef = 0; pec = 0; pet = 0;
    end else begin
      if (err_framing) n_ef++;
      if (err_checksum) n_ec++;
      if (err_timeout) n_et++;
      if ((err_framing && pef) || (err_checksum && pec) || (err_timeout && pet))
        wide++;
      pef = err_framing; pec = err_checksum; pet = err_timeout;
      if (report_valid && report_ready)
        got_q.push_back('{int'(report_buttons), int'($signed(report_dx)),
                           int'($signed(report_dy)), int'($signed(report_wheel))});
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(DIV); end
    uart_rx = stop; tick(DIV);
    uart_rx = 1'b1;
    if (!stop) tick(DIV);
  endtask

  task automatic send_frame(input int b, input int dx, input int dy,
                            input int wh, input bit bad);
    int s;
    s = (b + (dx & 255) + (dy & 255) + (wh & 255)) & 255;
    if (bad) s = (s + 1) & 255;
    send_byte(8'hA5, 1'b1);
    send_byte(8'(b), 1'b1);
    send_byte(8'(dx), 1'b1);
    send_byte(8'(dy), 1'b1);
    send_byte(8'(wh), 1'b1);
    send_byte(8'(s), 1'b1);
    tick(5);
  endtask

  function automatic int clamp(input int v);
    return (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction

  task automatic model_commit(input rep_t r, input bit rdy);
    if (rdy) exp_q.push_back(r);
    else if (!m_v) begin m_r = r; m_v = 1; end
    else begin
      m_r.b  = r.b;
      m_r.dx = clamp(m_r.dx + r.dx);
      m_r.dy = clamp(m_r.dy + r.dy);
      m_r.wh = clamp(m_r.wh + r.wh);
    end
  endtask

  task automatic check_reports(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_btn"}, got_q[i].b, exp_q[i].b);
      chk({tag, "_dx"}, got_q[i].dx, exp_q[i].dx);
      chk({tag, "_dy"}, got_q[i].dy, exp_q[i].dy);
      chk({tag, "_wh"}, got_q[i].wh, exp_q[i].wh);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clr_err();
    n_ef = 0; n_ec = 0; n_et = 0;
  endtask

  task automatic rand_rep(output rep_t r);
    r.b  = int'($urandom_range(0, 255));
    r.dx = int'($urandom_range(0, 255)) - 128;
    r.dy = int'($urandom_range(0, 255)) - 128;
    r.wh = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    rep_t r;
    int nbad;
    tick(5);
    chk("rst_valid", int'(report_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fields", int'(report_buttons | report_dx | report_dy | report_wheel), 0);
    chk("rst_err", int'(err_framing | err_checksum | err_timeout), 0);
    rst = 1'b0;
    tick(20);

    report_ready = 1'b1;
    send_frame(1, 5, -5, 0, 0);
    model_commit('{1, 5, -5, 0}, 1);
    check_reports("basic");
    chk("basic_err", n_ef + n_ec + n_et, 0);
    chk("basic_valid_low", int'(report_valid), 0);

    report_ready = 1'b0;
    send_frame(0, 127, 0, 0, 0);
    send_frame(2, 16, -128, 1, 0);
    chk("coal_valid", int'(report_valid), 1);
    chk("coal_btn", int'(report_buttons), 2);
    chk("coal_dx", int'($signed(report_dx)), 127);
    chk("coal_dy", int'($signed(report_dy)), -128);
    chk("coal_wh", int'($signed(report_wheel)), 1);
    report_ready = 1'b1;
    exp_q.push_back('{2, 127, -128, 1});
    tick(3);
    check_reports("coal");
    chk("coal_valid_low", int'(report_valid), 0);

    clr_err();
    send_frame(1, 5, -5, 0, 1);
    chk("cks_pulse", n_ec, 1);
    chk("cks_valid", int'(report_valid), 0);
    chk("cks_noreport", got_q.size(), 0);

    clr_err();
    send_byte(8'hA5, 1'b1);
    chk("tmo_busy", int'(busy), 1);
    send_byte(8'h01, 1'b1);
    tick(400);
    chk("tmo_pulse", n_et, 1);
    chk("tmo_busy_low", int'(busy), 0);
    rand_rep(r);
    send_frame(r.b, r.dx, r.dy, r.wh, 0);
    model_commit(r, 1);
    check_reports("tmo_after");

    clr_err();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h37, 1'b0);
    chk("frm_pulse", n_ef, 1);
    chk("frm_busy", int'(busy), 0);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    rand_rep(r);
    send_frame(r.b, r.dx, r.dy, r.wh, 0);
    model_commit(r, 1);
    chk("lead_err", n_ef + n_ec + n_et, 1);
    check_reports("lead");

    clr_err();
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      bit bad;
      bad = ($urandom_range(0, 3) == 0);
      rand_rep(r);
      send_frame(r.b, r.dx, r.dy, r.wh, bad);
      if (bad) nbad++;
      else model_commit(r, 1);
    end
    chk("rand_cks", n_ec, nbad);
    check_reports("rand");

    report_ready = 1'b0;
    m_v = 0;
    for (int i = 0; i < 4; i++) begin
      rand_rep(r);
      send_frame(r.b, r.dx, r.dy, r.wh, 0);
      model_commit(r, 0);
    end
    chk("rcoal_dx", int'($signed(report_dx)), m_r.dx);
    chk("rcoal_dy", int'($signed(report_dy)), m_r.dy);
    chk("rcoal_wh", int'($signed(report_wheel)), m_r.wh);
    report_ready = 1'b1;
    exp_q.push_back(m_r);
    m_v = 0;
    tick(3);
    check_reports("rcoal");

    report_ready = 1'b0;
    rand_rep(r);
    send_frame(r.b, r.dx, r.dy, r.wh, 0);
    chk("rst_pre_valid", int'(report_valid), 1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    uart_rx = 1'b0; tick(DIV);
    for (int i = 0; i < 4; i++) begin uart_rx = i[0]; tick(DIV); end
    rst = 1'b1;
    #1;
    chk("mid_valid", int'(report_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_fields", int'(report_buttons | report_dx | report_dy | report_wheel), 0);
    chk("mid_err", int'(err_framing | err_checksum | err_timeout), 0);
    m_v = 0;
    uart_rx = 1'b1;
    tick(20);
    rst = 1'b0;
    tick(20);
    report_ready = 1'b1;
    rand_rep(r);
    send_frame(r.b, r.dx, r.dy, r.wh, 0);
    model_commit(r, 1);
    check_reports("post_rst");

    chk("pulse_width", wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mouse_cmd_rx.md
UART_MOUSE_CMD_RX -- requirements
Module: uart_mouse_cmd_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 60000000, sync-domain clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_HZ/BAUD (integer division), DIV >= 4.
REQ-003 SHALL have parameter DELTA_W, default 8, width of dx/dy/wheel; legal values 8 and 16.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 600000, maximum clk cycles allowed between two byte stop-bits inside one frame.
REQ-005 SHALL have ports:
  clk  input  1  sync clock; all logic on rising edge.
  rst  input  1  asynchronous, active-high reset.
  uart_rx  input  1  asynchronous serial input, idle high, 8N1, LSB first.
  report_valid  output  1  mouse report pending.
  report_ready  input  1  consumer accepts report when high with report_valid.
  report_buttons  output  8  button bitmap.
  report_dx / report_dy / report_wheel  output  DELTA_W each  signed two's-complement deltas.
  err_framing / err_checksum / err_timeout  output  1 each  single-cycle error pulses.
  busy  output  1  parser not in IDLE.

Function
REQ-006 uart_rx SHALL pass a 2-flop synchroniser before any use.
REQ-007 Receiver SHALL detect start on a synchronised high-to-low edge, re-check low at DIV/2 cycles, else abandon silently.
REQ-008 Receiver SHALL sample 8 data bits at DIV-cycle intervals from the start mid-point, then sample stop bit; stop=0 -> pulse err_framing, discard byte, parser returns to IDLE.
REQ-009 Frame format: 0xA5 sync, buttons, dx, dy, wheel, checksum; multi-byte fields little-endian; NB = DELTA_W/8 bytes per delta; payload = 1+3*NB bytes.
REQ-010 Checksum SHALL be the mod-256 sum of payload bytes (sync excluded).
REQ-011 Parser states: IDLE (discard bytes other than 0xA5) -> PAYLOAD (count payload bytes) -> CHECK (await checksum byte) -> IDLE.
REQ-012 Checksum match SHALL commit the frame to the report register the cycle after the checksum byte's stop sample; mismatch SHALL pulse err_checksum and drop the frame.
REQ-013 In PAYLOAD/CHECK, a gap exceeding TIMEOUT_CYCLES since the last stop sample SHALL pulse err_timeout and return to IDLE; counter SHALL saturate, not wrap.
REQ-014 Handshake: report held stable while report_valid=1 and report_ready=0; transfer on cycle with both high; report_valid deasserts next cycle unless a commit occurs that same cycle.
REQ-015 Commit with report_valid=0, or coincident with a transfer: report register loaded with the new frame, report_valid=1.
REQ-016 Commit with report_valid=1 and no transfer (coalesce): buttons replaced; dx, dy, wheel = signed saturating sums clamped to [-2^(DELTA_W-1), 2^(DELTA_W-1)-1].
REQ-017 Error pulses SHALL be exactly one cycle wide and SHALL NOT alter the report register.
REQ-018 busy SHALL be 1 in PAYLOAD and CHECK, 0 in IDLE.
REQ-019 Commit-to-report_valid latency: 1 clk; uart_rx edge-to-detect latency: 2 clk (synchroniser).

Reset
REQ-020 rst=1 SHALL asynchronously force: parser IDLE, receiver idle, counters 0, synchroniser flops 1, report_valid=0, report fields 0, all err_* 0, busy 0.
REQ-021 Reset mid-byte or mid-frame SHALL discard partial data; the first frame after release SHALL start from a fresh start bit.
REQ-022 Report register content SHALL be lost on reset even if report_valid was 1.

Verification (CLK_HZ=1000000, BAUD=100000, DIV=10, DELTA_W=8, TIMEOUT_CYCLES=300)
REQ-023 Send A5 01 05 FB 00 01, report_ready=1 -> one report_valid pulse, buttons=0x01, dx=+5, dy=-5, wheel=0, no errors.
REQ-024 report_ready=0, send A5 00 7F 00 00 7F then A5 02 10 80 01 93 -> single report: buttons=0x02, dx=+127 (saturated), dy=-128, wheel=+1.
REQ-025 Send A5 01 05 FB 00 02 -> err_checksum one-cycle pulse, report_valid stays 0.
REQ-026 Send A5 01 then idle 400 cycles -> err_timeout pulse, busy falls; following valid frame accepted normally.
REQ-027 Byte with stop bit driven 0 during PAYLOAD -> err_framing pulse, parser IDLE; leading bytes 00 FF before A5 frame ignored without error.
REQ-028 Assert rst mid-way through dy byte with report_valid=1 -> all outputs 0 immediately; next full frame decodes correctly.
